// File: rtl/uart_tx.sv
// UART transmit serializer: start bit, LSB-first data, optional parity, one stop bit.
// One serial bit per CLK cycle; TX_OUT and busy come straight from flops.
module uart_tx #(
   parameter int DATA_WIDTH = 8
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic [DATA_WIDTH-1:0] P_DATA,
   input  logic                  Data_Valid,
   input  logic                  PAR_EN,
   input  logic                  PAR_TYP,
   output logic                  TX_OUT,
   output logic                  busy
);

   localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } state_t;

   state_t                state, state_nxt;
   logic [DATA_WIDTH-1:0] data_r, data_nxt;
   logic                  par_en_r, par_en_nxt;
   logic                  par_typ_r, par_typ_nxt;
   logic [CNT_W-1:0]      cnt, cnt_nxt;
   logic                  tx_nxt, busy_nxt;
   logic                  accept;

   // Even parity is the XOR of the data bits; odd parity inverts it.
   function automatic logic parity_bit(input logic [DATA_WIDTH-1:0] d, input logic odd);
      return (^d) ^ odd;
   endfunction

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state     <= IDLE;
         data_r    <= '0;
         par_en_r  <= 1'b0;
         par_typ_r <= 1'b0;
         cnt       <= '0;
         TX_OUT    <= 1'b1;
         busy      <= 1'b0;
      end else begin
         state     <= state_nxt;
         data_r    <= data_nxt;
         par_en_r  <= par_en_nxt;
         par_typ_r <= par_typ_nxt;
         cnt       <= cnt_nxt;
         TX_OUT    <= tx_nxt;
         busy      <= busy_nxt;
      end
   end

   always_comb begin
      state_nxt   = state;
      data_nxt    = data_r;
      par_en_nxt  = par_en_r;
      par_typ_nxt = par_typ_r;
      cnt_nxt     = cnt;
      accept      = 1'b0;

      case (state)
         IDLE: begin
            if (Data_Valid) accept = 1'b1;
         end
         START: begin
            state_nxt = DATA;
            cnt_nxt   = '0;
         end
         DATA: begin
            if (cnt == LAST_BIT) begin
               state_nxt = par_en_r ? PARITY : STOP;
            end else begin
               cnt_nxt = cnt + CNT_W'(1);
            end
         end
         PARITY: begin
            state_nxt = STOP;
         end
         STOP: begin
            // A request seen here chains the next frame with no idle gap.
            if (Data_Valid) accept = 1'b1;
            else            state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
         end
      endcase

      if (accept) begin
         state_nxt   = START;
         cnt_nxt     = '0;
         data_nxt    = P_DATA;
         par_en_nxt  = PAR_EN;
         par_typ_nxt = PAR_TYP;
      end
   end

   // Output flops are loaded with the value for the state being entered.
   always_comb begin
      tx_nxt   = 1'b1;
      busy_nxt = (state_nxt != IDLE);
      case (state_nxt)
         START:   tx_nxt = 1'b0;
         DATA:    tx_nxt = data_nxt[cnt_nxt];
         PARITY:  tx_nxt = parity_bit(data_r, par_typ_r);
         default: tx_nxt = 1'b1;
      endcase
   end

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: idle line, framing with and without parity,
// back-to-back frames, ignored requests and asynchronous reset mid-frame.
module tb_uart_tx;

   logic       CLK;
   logic       RST;
   logic [7:0] P_DATA;
   logic       Data_Valid;
   logic       PAR_EN;
   logic       PAR_TYP;
   logic       TX_OUT;
   logic       busy;

   int n_checks = 0;
   int n_fail   = 0;

   uart_tx #(.DATA_WIDTH(8)) dut (
      .CLK        (CLK),
      .RST        (RST),
      .P_DATA     (P_DATA),
      .Data_Valid (Data_Valid),
      .PAR_EN     (PAR_EN),
      .PAR_TYP    (PAR_TYP),
      .TX_OUT     (TX_OUT),
      .busy       (busy)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic chk(input string tag, input logic got, input logic exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%b exp=%b t=%0t", tag, got, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic chk_idle(input string tag, input int cycles);
      for (int i = 0; i < cycles; i++) begin
         chk($sformatf("%s_tx%0d", tag, i), TX_OUT, 1'b1);
         chk($sformatf("%s_busy%0d", tag, i), busy, 1'b0);
         tick();
      end
   endtask

   task automatic send(input logic [7:0] d, input logic pen, input logic ptyp);
      P_DATA     = d;
      PAR_EN     = pen;
      PAR_TYP    = ptyp;
      Data_Valid = 1'b1;
      tick();
      Data_Valid = 1'b0;
   endtask

   // Called just after the accepting edge; exp[i] is the line value in slot i.
   task automatic frame(input string tag, input logic [15:0] exp, input int len,
                        input logic [15:0] dv_mask, input int chg_slot,
                        input logic [7:0] chg_data);
      for (int i = 0; i < len; i++) begin
         chk($sformatf("%s_tx%0d", tag, i), TX_OUT, exp[i]);
         chk($sformatf("%s_busy%0d", tag, i), busy, 1'b1);
         Data_Valid = dv_mask[i];
         if (i == chg_slot) P_DATA = chg_data;
         tick();
      end
      Data_Valid = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL timeout t=%0t", $time);
      $fatal(1, "timeout");
   end

   initial begin
      RST        = 1'b0;
      P_DATA     = 8'h00;
      Data_Valid = 1'b0;
      PAR_EN     = 1'b0;
      PAR_TYP    = 1'b0;
      repeat (3) tick();
      chk("rst_tx", TX_OUT, 1'b1);
      chk("rst_busy", busy, 1'b0);
      RST = 1'b1;

      chk_idle("idle", 20);

      send(8'hA5, 1'b0, 1'b0);
      frame("a5_np", 16'h034A, 10, 16'h0000, -1, 8'h00);
      chk_idle("a5_np_end", 2);

      send(8'hA5, 1'b1, 1'b0);
      frame("a5_even", 16'h054A, 11, 16'h0000, -1, 8'h00);
      chk_idle("a5_even_end", 2);

      send(8'hA5, 1'b1, 1'b1);
      frame("a5_odd", 16'h074A, 11, 16'h0000, -1, 8'h00);
      chk_idle("a5_odd_end", 2);

      // Inputs scrambled right after acceptance; frame must use latched values.
      send(8'h07, 1'b1, 1'b0);
      P_DATA  = 8'h00;
      PAR_EN  = 1'b0;
      PAR_TYP = 1'b1;
      frame("x07_even", 16'h060E, 11, 16'h0000, -1, 8'h00);
      chk_idle("x07_end", 2);

      // Data_Valid held, P_DATA moves to 0xFF mid-frame; 0xFF chains after stop.
      PAR_EN  = 1'b0;
      PAR_TYP = 1'b0;
      send(8'h3C, 1'b0, 1'b0);
      frame("b2b0", 16'h0278, 10, 16'h03FF, 3, 8'hFF);
      frame("b2b1", 16'h03FE, 10, 16'h0000, -1, 8'h00);
      chk_idle("b2b_end", 3);

      // Requests during START, DATA and PARITY are dropped.
      send(8'hA5, 1'b1, 1'b1);
      frame("ign", 16'h074A, 11, 16'h0215, -1, 8'h00);
      chk_idle("ign_end", 4);

      // Reset asserted while data bit 3 is on the line.
      send(8'hA5, 1'b0, 1'b0);
      repeat (4) tick();
      chk("pre_rst_tx", TX_OUT, 1'b0);
      chk("pre_rst_busy", busy, 1'b1);
      #2;
      RST = 1'b0;
      #1;
      chk("mid_rst_tx", TX_OUT, 1'b1);
      chk("mid_rst_busy", busy, 1'b0);
      repeat (2) tick();
      RST = 1'b1;
      chk_idle("post_rst", 12);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
